tl_cmd_arbiter: RTL
===================

# tl_cmd_arbiter

Command arbiter in front of a traffic-light controller's command port (`cmd_type`/`cmd_valid`/`cmd_data`). Collects commands from up to `REQ_NUM` requesters (host UART, maintenance panel, emergency input, scheduler), picks one per slot by round-robin, and issues it as a single-cycle command. Enforces a minimum gap between issued commands and rejects illegal command types. Sits between the requester blocks and the traffic-light controller.

## Interface
- `REQ_NUM`, 4: requester count, legal 2..8.
- `GAP_CYCLES`, 2: idle cycles forced after each issued command, 0..65535.
- `clk_i`  in  1  clock.
- `arst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  REQ_NUM  per-requester command valid.
- `req_type_i`  in  3*REQ_NUM  per-requester command type; requester k uses bits [3k+2:3k].
- `req_data_i`  in  16*REQ_NUM  per-requester data; requester k uses bits [16k+15:16k].
- `req_ready_o`  out  REQ_NUM  one-hot accept strobe.
- `cmd_type_o`  out  3  issued command type.
- `cmd_valid_o`  out  1  issued command strobe, one cycle.
- `cmd_data_o`  out  16  issued command data.
- `grant_id_o`  out  $clog2(REQ_NUM)  index of the last accepted requester.
- `err_o`  out  1  one-cycle pulse on an illegal type (6 or 7).
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Command codes: 0 TURN_ON, 1 TURN_OFF, 2 SET_UNC, 3 SET_GREEN_TIME, 4 SET_RED_TIME, 5 SET_YELLOW_TIME. 6 and 7 are illegal.
- FSM states:
  - IDLE: if any `req_valid_i` is high, pick winner w and go to ISSUE (legal type) or ERR (illegal type). Otherwise stay.
  - ISSUE: one cycle. Next state is GAP if `GAP_CYCLES`>0, else IDLE.
  - GAP: counts `GAP_CYCLES` cycles, then IDLE.
  - ERR: one cycle, then IDLE. No gap is applied.
- Handshake:
  - `req_ready_o[w]` is combinational: high only in IDLE, only for the winner, in the same cycle as `req_valid_i[w]`.
  - valid&ready is the accept. Requester holds type/data stable until accepted.
  - Withdrawing valid before accept is allowed.
- On accept: register `req_type_i[w]` and `req_data_i[w]` into the output regs. `grant_id_o`<=w. Round-robin pointer <=w.
- Round-robin: search starts at pointer+1 mod `REQ_NUM`. The first valid requester wins. After reset, requester 0 has top priority.
- Only the winner is accepted; losers keep waiting. No requester is starved: worst-case wait is (`REQ_NUM`-1) slots.
- `cmd_type_o`/`cmd_data_o` hold their last value outside ISSUE. Only `cmd_valid_o` qualifies them.

## Timing
- Reset values: `cmd_valid_o`=0, `cmd_type_o`=0, `cmd_data_o`=0, `grant_id_o`=0, `err_o`=0, `busy_o`=0, `req_ready_o`=0. Pointer = `REQ_NUM`-1. State = IDLE. Gap counter = 0.
- Latency: accept at cycle T -> `cmd_valid_o` high at T+1 for exactly one cycle. `cmd_valid_o`, `err_o` and `busy_o` are registered, decoded from state.
- Illegal type accepted at T -> `err_o` high at T+1 with `cmd_valid_o`=0. Next accept is possible at T+2.
- Throughput: one command per (2+`GAP_CYCLES`) cycles.
  - With `GAP_CYCLES`=0, back-to-back accepts occur every 2 cycles: IDLE, ISSUE.
  - Gap counter is 16-bit and counts 0..`GAP_CYCLES`-1.
- Reset mid-operation: asserting `arst_i` in ISSUE drops `cmd_valid_o` immediately (asynchronous). The in-flight command is lost, not replayed.
- A request that arrives during ISSUE, GAP or ERR waits; no ready is given outside IDLE.

## Configuration
- `TL_ARB_URGENT_PRIO_EN`:
  - Defined: in IDLE, any valid TURN_OFF (1) or SET_UNC (2) request wins over round-robin. Ties among urgent requests are resolved by round-robin order. The pointer still updates to the winner.
  - Undefined: pure round-robin; type is ignored for arbitration.

## Test plan
- Single requester: req 2 sends type 3, data 16'd8000 at T -> `req_ready_o`=4'b0100 at T. At T+1: `cmd_valid_o`=1, `cmd_type_o`=3, `cmd_data_o`=8000, `grant_id_o`=2. `busy_o` high for 1+`GAP_CYCLES` cycles.
- Fairness: all 4 requesters hold valid continuously after reset -> grants in order 0,1,2,3,0. Successive `cmd_valid_o` pulses are spaced 4 cycles apart (`GAP_CYCLES`=2).
- Illegal type: req 1 sends type 7 -> ready in the accept cycle. `err_o` pulses 1 cycle, `cmd_valid_o` stays 0. The next pending request is accepted 2 cycles after the first accept.
- Urgent (macro defined): pointer at 0; req 1 sends type 4 and req 3 sends type 1 in the same cycle -> req 3 granted first, then req 1.
- Reset mid-issue: assert `arst_i` asynchronously while `cmd_valid_o`=1 -> all outputs are 0 before the next clock edge. After release, requester 0 is granted first.
- Gap zero: `GAP_CYCLES`=0, requesters 0 and 1 both valid -> `cmd_valid_o` pulses at T+1 and T+3.

Source files
------------

// File: rtl/tl_cmd_arbiter_if.sv
// Requester-side and controller-side signals of the traffic-light command arbiter.
// The master modport is the requester/controller side; the slave modport is the arbiter.
interface tl_cmd_arbiter_if #(
  parameter int REQ_NUM = 4
);
  localparam int ID_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]    req_valid_i;
  logic [3*REQ_NUM-1:0]  req_type_i;
  logic [16*REQ_NUM-1:0] req_data_i;
  logic [REQ_NUM-1:0]    req_ready_o;
  logic [2:0]            cmd_type_o;
  logic                  cmd_valid_o;
  logic [15:0]           cmd_data_o;
  logic [ID_W-1:0]       grant_id_o;
  logic                  err_o;
  logic                  busy_o;

  modport master (
    output req_valid_i, req_type_i, req_data_i,
    input  req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, grant_id_o, err_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_type_i, req_data_i,
    output req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, grant_id_o, err_o, busy_o
  );
endinterface

// File: rtl/tl_cmd_arbiter.sv
// Round-robin command arbiter feeding a traffic-light controller, with a post-issue gap.
// Define TL_ARB_URGENT_PRIO_EN to let TURN_OFF/SET_UNC requests pre-empt round-robin order.
module tl_cmd_arbiter #(
  parameter int REQ_NUM    = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic             clk_i,
  input logic             arst_i,
  tl_cmd_arbiter_if.slave bus
);
  localparam int              ID_W      = $clog2(REQ_NUM);
  localparam logic [ID_W:0]   REQ_NUM_W = (ID_W+1)'(REQ_NUM);
  localparam logic [15:0]     GAP_LAST  = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_grant;
  logic [15:0]       r_gap_cnt;
  logic [2:0]        r_cmd_type;
  logic [15:0]       r_cmd_data;
  logic              r_cmd_valid;
  logic              r_err;
  logic              r_busy;

  logic [2:0]        w_type_arr [REQ_NUM];
  logic [15:0]       w_data_arr [REQ_NUM];
  logic [REQ_NUM-1:0] w_urgent;
  logic [REQ_NUM-1:0] w_cand;
  logic [REQ_NUM-1:0] w_ready;
  logic [ID_W:0]     w_sum;
  logic [ID_W-1:0]   w_idx;
  logic [ID_W-1:0]   w_win;
  logic              w_found;
  logic [2:0]        w_win_type;
  logic              w_illegal;
  logic              w_accept;

  always_comb begin
    for (int k = 0; k < REQ_NUM; k++) begin
      w_type_arr[k] = bus.req_type_i[3*k +: 3];
      w_data_arr[k] = bus.req_data_i[16*k +: 16];
      w_urgent[k]   = bus.req_valid_i[k] &&
                      ((w_type_arr[k] == 3'd1) || (w_type_arr[k] == 3'd2));
    end
  end

`ifdef TL_ARB_URGENT_PRIO_EN
  assign w_cand = (|w_urgent) ? w_urgent : bus.req_valid_i;
`else
  assign w_cand = bus.req_valid_i;
`endif

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    // Walk requesters starting just after the last winner, wrapping at REQ_NUM.
    for (int i = 1; i <= REQ_NUM; i++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(i);
      if (w_sum >= REQ_NUM_W) w_sum = w_sum - REQ_NUM_W;
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_type = w_type_arr[w_win];
  assign w_illegal  = (w_win_type[2:1] == 2'b11);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ready  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found && !arst_i) begin
          w_accept       = 1'b1;
          w_ready[w_win] = 1'b1;
          w_next         = w_illegal ? S_ERR : S_ISSUE;
        end
      end
      S_ISSUE: w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= S_IDLE;
      r_ptr       <= ID_W'(REQ_NUM - 1);
      r_grant     <= '0;
      r_gap_cnt   <= '0;
      r_cmd_type  <= '0;
      r_cmd_data  <= '0;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_valid <= (w_next == S_ISSUE);
      r_err       <= (w_next == S_ERR);
      r_busy      <= (w_next != S_IDLE);
      if (w_accept) begin
        r_grant <= w_win;
        r_ptr   <= w_win;
        // An illegal command never reaches the controller, so the command regs keep their value.
        if (!w_illegal) begin
          r_cmd_type <= w_win_type;
          r_cmd_data <= w_data_arr[w_win];
        end
      end
      if (r_state == S_GAP) begin
        r_gap_cnt <= (r_gap_cnt == GAP_LAST) ? 16'd0 : r_gap_cnt + 16'd1;
      end
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.cmd_type_o  = r_cmd_type;
  assign bus.cmd_valid_o = r_cmd_valid;
  assign bus.cmd_data_o  = r_cmd_data;
  assign bus.grant_id_o  = r_grant;
  assign bus.err_o       = r_err;
  assign bus.busy_o      = r_busy;
endmodule
